vpu_dispatch: RTL and testbench

VPU_DISPATCH -- requirements
Module: vpu_dispatch

---
 rtl/vpu_pkg.sv | 28 ++
 rtl/vpu_instr_fifo.sv | 71 +++++++
 rtl/vpu_dispatch.sv | 119 +++++++++++
 tb/tb_vpu_dispatch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// vpu_pkg: shared types and constants for the VPU dispatch slice.
// Holds the dispatch FSM state enum, default width and opcode classes.
package vpu_pkg;

  localparam int VPU_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } vpu_state_e;

  localparam logic [3:0] VPU_OPC_VALU = 4'hA;
  localparam logic [3:0] VPU_OPC_VLD  = 4'hB;
  localparam logic [3:0] VPU_OPC_VST  = 4'hC;
  localparam logic [3:0] VPU_OPC_VCFG = 4'hD;

  function automatic logic is_vpu_op(
    input logic [3:0] opc
  );
    return (opc == VPU_OPC_VALU) ||
           (opc == VPU_OPC_VLD)  ||
           (opc == VPU_OPC_VST)  ||
           (opc == VPU_OPC_VCFG);
  endfunction

endpackage

// File: rtl/vpu_instr_fifo.sv
// vpu_instr_fifo: instruction queue feeding the VPU dispatcher.
// Head stays in place until the dispatcher pops it on completion.
module vpu_instr_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = VPU_INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [INSTR_W-1:0]       data_i,
  input  logic                     pop_i,
  output logic [INSTR_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is qualified by the count, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vpu_dispatch.sv
// vpu_dispatch: queues VPU instructions from the CPU and launches them.
// Define VPU_DISPATCH_TIMEOUT_EN to add the WAIT_* watchdog.
module vpu_dispatch
  import vpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = VPU_INSTR_W,
  parameter int TO_CYC  = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_valid,
  input  logic [INSTR_W-1:0]     cpu_instr,
  input  logic                   cpu_sync,
  output logic                   cpu_stall,
  output logic                   vpu_start,
  output logic [INSTR_W-1:0]     vpu_instr,
  input  logic                   vpu_rdy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   timeout_err
);

  vpu_state_e state_q, state_d;
  logic       pop;
  logic       full;
  logic       empty;
  logic       to_hit;

  vpu_instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cpu_valid),
    .data_i  (cpu_instr),
    .pop_i   (pop),
    .head_o  (vpu_instr),
    .count_o (q_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cpu_stall = full |
    (cpu_sync & ~(empty & (state_q == IDLE)));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty) state_d = ISSUE;
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (to_hit)        state_d = IDLE;
        else if (!vpu_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (to_hit || vpu_rdy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: launch pulse and head pop on completion
  always_comb begin
    vpu_start = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      ISSUE:     vpu_start = 1'b1;
      WAIT_ACK:  pop = to_hit;
      WAIT_DONE: pop = to_hit | vpu_rdy;
      default:   pop = 1'b0;
    endcase
  end

`ifdef VPU_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] WD_ONE  = TW'(1);

  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          in_wait;
  logic          nxt_wait;

  assign in_wait  = (state_q == WAIT_ACK) |
                    (state_q == WAIT_DONE);
  assign nxt_wait = (state_d == WAIT_ACK) |
                    (state_d == WAIT_DONE);
  assign to_hit   = in_wait & (wd_q == TO_LAST);
  assign timeout_err = err_q;

  // Count consecutive WAIT_* cycles; the flag is sticky
  always_comb begin
    wd_d  = '0;
    err_d = err_q | to_hit;
    if (in_wait && nxt_wait) wd_d = wd_q + WD_ONE;
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_dispatch.sv
// tb_vpu_dispatch: directed scoreboard bench for vpu_dispatch.
// A VPU model answers launches; a monitor checks issue order.
`timescale 1ns/1ps
module tb_vpu_dispatch;

  localparam int DEPTH = 4;
  localparam int IW    = 16;
  localparam int TO    = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_valid = 1'b0;
  logic [IW-1:0] cpu_instr = '0;
  logic          cpu_sync = 1'b0;
  logic          vpu_rdy = 1'b1;
  logic          cpu_stall;
  logic          vpu_start;
  logic [IW-1:0] vpu_instr;
  logic [2:0]    q_count;
  logic          timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int issued = 0;
  int n0     = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] cur_instr = '0;
  int vpu_lat  = 5;
  bit vpu_hang = 1'b0;
  bit vpu_busy = 1'b0;
  bit prev_start = 1'b0;

  always #5 clk = ~clk;

  vpu_dispatch #(
    .DEPTH   (DEPTH),
    .INSTR_W (IW),
    .TO_CYC  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_valid   (cpu_valid),
    .cpu_instr   (cpu_instr),
    .cpu_sync    (cpu_sync),
    .cpu_stall   (cpu_stall),
    .vpu_start   (vpu_start),
    .vpu_instr   (vpu_instr),
    .vpu_rdy     (vpu_rdy),
    .q_count     (q_count),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or bad event", nm);
  endtask

  // Call at posedge+1; returns at posedge+1 after acceptance
  task automatic push(input logic [IW-1:0] v);
    int n = 0;
    cpu_valid = 1'b1;
    cpu_instr = v;
    @(negedge clk);
    while (cpu_stall && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("push_timeout");
    @(posedge clk);
    exp_q.push_back(v);
    #1 cpu_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_count != 0 || exp_q.size() != 0 ||
            vpu_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // VPU model: drops rdy the cycle after a launch
  initial forever begin
    @(negedge clk);
    if (vpu_start && !rst) begin
      @(posedge clk);
      #1;
      vpu_rdy  = 1'b0;
      vpu_busy = 1'b1;
      while (vpu_hang && !rst) @(posedge clk);
      if (!rst) begin
        repeat (vpu_lat) @(posedge clk);
        #1;
      end
      vpu_rdy  = 1'b1;
      vpu_busy = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each launch
  always @(negedge clk) begin
    if (!rst) begin
      if (vpu_start) begin
        chk("start_pulse", {31'd0, prev_start}, 0);
        if (exp_q.size() == 0) begin
          fail("unexpected_start");
        end else begin
          cur_instr = exp_q.pop_front();
          chk("issue_order", vpu_instr, cur_instr);
        end
        issued++;
      end else if (vpu_busy && !vpu_hang) begin
        chk("instr_stable", vpu_instr, cur_instr);
      end
      prev_start = vpu_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound hit");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_qcount", q_count, 0);
    chk("rst_start", vpu_start, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_err", timeout_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single issue, latency and completion
    vpu_lat = 5;
    @(posedge clk);
    #1;
    n0 = issued;
    push(16'hA123);
    @(negedge clk);
    chk("lat_c1_start", vpu_start, 0);
    @(negedge clk);
    chk("lat_c2_start", vpu_start, 1);
    chk("lat_c2_instr", vpu_instr, 16'hA123);
    repeat (6) @(negedge clk);
    chk("single_q_busy", q_count, 1);
    @(negedge clk);
    chk("single_q_pop", q_count, 0);
    @(posedge clk);
    #1;
    chk("single_issued", issued - n0, 1);

    // fill to DEPTH with a slow VPU
    vpu_lat = 12;
    n0 = issued;
    push(16'hB001);
    push(16'hB002);
    push(16'hB003);
    push(16'hB004);
    cpu_valid = 1'b1;
    cpu_instr = 16'hB005;
    @(negedge clk);
    chk("fill_count", q_count, 4);
    chk("fill_stall", cpu_stall, 1);
    @(posedge clk);
    #1;
    push(16'hB005);
    @(negedge clk);
    chk("fill_after", q_count, 4);
    @(posedge clk);
    #1;
    drain();
    chk("fill_issued", issued - n0, 5);

    // pointer wrap with ten instructions
    vpu_lat = 2;
    n0 = issued;
    for (int i = 0; i < 10; i++) begin
      push(16'hC000 + 16'(i * 17));
    end
    drain();
    chk("wrap_issued", issued - n0, 10);

    // sync holds the CPU until fully idle
    vpu_lat = 3;
    push(16'hD001);
    push(16'hD002);
    cpu_sync = 1'b1;
    begin
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
        if (q_count != 0) begin
          chk("sync_stall_hi", cpu_stall, 1);
        end else begin
          chk("sync_stall_lo", cpu_stall, 0);
          done = 1'b1;
        end
      end
      if (!done) fail("sync_timeout");
    end
    cpu_sync = 1'b0;
    @(posedge clk);
    #1;
    drain();

`ifdef VPU_DISPATCH_TIMEOUT_EN
    // watchdog drops a hung head
    vpu_hang = 1'b1;
    vpu_lat  = 3;
    n0 = issued;
    push(16'hF001);
    push(16'hF002);
    @(negedge clk);
    chk("to_start", vpu_start, 1);
    repeat (20) @(negedge clk);
    chk("to_err_pre", timeout_err, 0);
    @(negedge clk);
    chk("to_err_set", timeout_err, 1);
    chk("to_dropped", q_count, 1);
    vpu_hang = 1'b0;
    @(posedge clk);
    #1;
    drain();
    chk("to_issued", issued - n0, 2);
    chk("to_sticky", timeout_err, 1);
`endif

    // asynchronous reset mid WAIT_DONE
    vpu_hang = 1'b1;
    n0 = issued;
    push(16'hE001);
    push(16'hE002);
    push(16'hE003);
    repeat (4) @(negedge clk);
    chk("rst_pre_count", q_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_qcount", q_count, 0);
    chk("arst_start", vpu_start, 0);
    chk("arst_stall", cpu_stall, 0);
    chk("arst_err", timeout_err, 0);
    exp_q.delete();
    vpu_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push(16'hE004);
    drain();
    chk("post_rst_issued", issued - n0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
